// File: rtl/bram_mux_pkg.sv
// Shared constants and helpers for the BRAM write-port input arbiter/mux.
package bram_mux_pkg;

  localparam logic MODE_STATIC = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Channel-index width; never below one bit, even for a two-channel mux.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int N  = 6,
  parameter int CW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [CW-1:0] gnt_idx
);

  always_comb begin
    int  j;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      // Wrap the scan position; ptr is always held below N.
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = CW'(j);
      end
    end
  end

endmodule

// File: rtl/bram_in_arb_mux.sv
// Selects one of N_IN producer channels into a single registered BRAM write port,
// either by a static select or by round-robin arbitration.
module bram_in_arb_mux
  import bram_mux_pkg::*;
#(
  parameter  int N_IN = 6,
  parameter  int DW   = 32,
  localparam int CW   = clog2_min1(N_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [CW-1:0]     sel,
  input  logic [N_IN-1:0]   in_valid,
  input  logic [N_IN*DW-1:0] in_data,
  output logic [N_IN-1:0]   in_ready,
  output logic [DW-1:0]     dout,
  output logic [CW-1:0]     dout_ch,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              sel_err
);

  // Handshake: a word moves on channel i in any cycle where in_valid[i] && in_ready[i];
  // it is presented on dout one cycle later and held until dout_valid && dout_ready.
  // in_ready is one-hot or zero and only ever follows the matching in_valid.

  localparam logic [CW:0] N_IN_W = (CW+1)'(N_IN);

  logic [CW-1:0]   rr_ptr;
  logic [N_IN-1:0] rr_gnt;
  logic [CW-1:0]   rr_idx;
  logic [N_IN-1:0] st_gnt;
  logic [N_IN-1:0] gnt_vec;
  logic [CW-1:0]   gnt_idx;
  logic [DW-1:0]   gnt_data;
  logic [CW-1:0]   next_ptr;
  logic            load_en;
  logic            sel_ok;
  logic            transfer;
  logic            sel_err_nxt;

  rr_arbiter #(
    .N  (N_IN),
    .CW (CW)
  ) u_rr (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx)
  );

  always_comb begin
    load_en = !dout_valid || dout_ready;
    sel_ok  = ({1'b0, sel} < N_IN_W);
    st_gnt  = '0;
    for (int i = 0; i < N_IN; i++) begin
      st_gnt[i] = (sel == CW'(i)) && in_valid[i];
    end
    if (mode == MODE_RR) begin
      gnt_vec = rr_gnt;
      gnt_idx = rr_idx;
    end else begin
      gnt_vec = st_gnt;
      gnt_idx = sel;
    end
    in_ready = (!rst && load_en) ? gnt_vec : '0;
    transfer = |in_ready;
    gnt_data = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (gnt_idx == CW'(i)) gnt_data = in_data[i*DW +: DW];
    end
    next_ptr    = (gnt_idx == CW'(N_IN-1)) ? '0 : gnt_idx + CW'(1);
    sel_err_nxt = (mode == MODE_STATIC) && !sel_ok && (|in_valid);
  end

  // The output register and rr_ptr only move when the stage is empty or draining,
  // so a stalled word is never overwritten whatever mode/sel do meanwhile.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_ch    <= '0;
      dout_valid <= 1'b0;
      sel_err    <= 1'b0;
      rr_ptr     <= '0;
    end else begin
      sel_err <= sel_err_nxt;
      if (load_en) begin
        dout_valid <= transfer;
        if (transfer) begin
          dout    <= gnt_data;
          dout_ch <= gnt_idx;
          rr_ptr  <= next_ptr;
        end
      end
    end
  end

endmodule

// File: tb/tb_bram_in_arb_mux.sv
// Scoreboard bench for bram_in_arb_mux: reset, static select, bad select, RR fairness, stall, mode switch.
module tb_bram_in_arb_mux;

  localparam int N  = 6;
  localparam int DW = 32;
  localparam int CW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              mode;
  logic [CW-1:0]     sel;
  logic [N-1:0]      in_valid;
  logic [N*DW-1:0]   in_data;
  logic [N-1:0]      in_ready;
  logic [DW-1:0]     dout;
  logic [CW-1:0]     dout_ch;
  logic              dout_valid;
  logic              dout_ready;
  logic              sel_err;

  logic [DW-1:0]     d [N];
  logic [CW+DW-1:0]  exp_q[$];
  int                compared = 0;
  int                mismatched = 0;
  int                m_ptr = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) in_data[i*DW +: DW] = d[i];
  end

  bram_in_arb_mux #(.N_IN(N), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .sel        (sel),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .dout       (dout),
    .dout_ch    (dout_ch),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .sel_err    (sel_err)
  );

  // Output side of the scoreboard: every accepted output word must match the queue head.
  always @(negedge clk) begin
    if (!rst && dout_valid && dout_ready) begin
      logic [CW+DW-1:0] e;
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL out_word: got ch=%0d data=%h, required no word (queue empty)", dout_ch, dout);
      end else begin
        e = exp_q.pop_front();
        if ({dout_ch, dout} !== e) begin
          mismatched++;
          $display("FAIL out_word: got ch=%0d data=%h, required ch=%0d data=%h",
                   dout_ch, dout, e[CW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference round-robin pick for the expected grant.
  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic int ptr_after(input int g);
    return (g == N-1) ? 0 : g + 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) d[i] = $urandom_range(32'hFFFF_FFFF, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = '0;
    repeat (2) step();
    rst = 1'b0;
    m_ptr = 0;
  endtask

  task automatic drain();
    int n;
    in_valid   = '0;
    dout_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain_timeout: got %0d words pending, required 0", exp_q.size());
      exp_q.delete();
    end
    step();
    compared++;
    if (dout_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL idle_valid: got dout_valid=%b, required 0", dout_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '1; dout_ready = 1'b1;
    for (int i = 0; i < N; i++) d[i] = 32'hA0 + i;
    repeat (3) begin
      @(negedge clk);
      compared++;
      if (in_ready !== '0) begin
        mismatched++;
        $display("FAIL reset_in_ready: got %b, required 000000", in_ready);
      end
    end
    @(posedge clk);
    #1;
    in_valid = '0;
    rst = 1'b0;
    compared++;
    if ({dout_valid, dout, dout_ch, sel_err} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got valid=%b dout=%h ch=%0d err=%b, required all 0",
               dout_valid, dout, dout_ch, sel_err);
    end
    m_ptr = 0;
  endtask

  task automatic test_static();
    mode = 1'b0; sel = 3'd3; in_valid = '1; dout_ready = 1'b1;
    for (int i = 0; i < N; i++) d[i] = 32'hA0 + i;
    repeat (5) begin
      @(negedge clk);
      compared++;
      if (in_ready !== 6'b001000) begin
        mismatched++;
        $display("FAIL static_ready: got %b, required 001000", in_ready);
      end
      exp_q.push_back({3'd3, 32'hA3});
      m_ptr = ptr_after(3);
      step();
    end
    drain();
  endtask

  task automatic test_bad_sel();
    mode = 1'b0; sel = 3'd7; in_valid = 6'b000001; dout_ready = 1'b1;
    rand_data();
    @(negedge clk);
    compared++;
    if (in_ready !== '0) begin
      mismatched++;
      $display("FAIL badsel_ready: got %b, required 000000", in_ready);
    end
    step();
    compared++;
    if (sel_err !== 1'b1 || dout_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL badsel_err: got err=%b valid=%b, required err=1 valid=0", sel_err, dout_valid);
    end
    sel = 3'd0;
    @(negedge clk);
    compared++;
    if (in_ready !== 6'b000001) begin
      mismatched++;
      $display("FAIL goodsel_ready: got %b, required 000001", in_ready);
    end
    exp_q.push_back({3'd0, d[0]});
    m_ptr = ptr_after(0);
    step();
    in_valid = '0;
    compared++;
    if (sel_err !== 1'b0) begin
      mismatched++;
      $display("FAIL goodsel_err: got %b, required 0", sel_err);
    end
    drain();
  endtask

  task automatic rr_run(input logic [N-1:0] v, input int cycles);
    int g;
    in_valid = v;
    for (int c = 0; c < cycles; c++) begin
      rand_data();
      @(negedge clk);
      g = rr_pick(v, m_ptr);
      compared++;
      if (in_ready !== (N'(1) << g)) begin
        mismatched++;
        $display("FAIL rr_ready: cycle %0d got %b, required channel %0d", c, in_ready, g);
      end
      exp_q.push_back({CW'(g), d[g]});
      m_ptr = ptr_after(g);
      step();
    end
  endtask

  task automatic test_rr_fairness();
    do_reset();
    mode = 1'b1; sel = 3'd5; dout_ready = 1'b1;
    rr_run(6'b111111, 12);
    rr_run(6'b100100, 4);
    drain();
  endtask

  task automatic test_stall();
    int g;
    logic [DW-1:0] sd;
    mode = 1'b1; dout_ready = 1'b1;
    rr_run(6'b111111, 1);
    g  = (m_ptr == 0) ? N-1 : m_ptr - 1;
    sd = exp_q[exp_q.size()-1][DW-1:0];
    dout_ready = 1'b0;
    repeat (4) begin
      rand_data();
      @(negedge clk);
      compared++;
      if (dout_valid !== 1'b1 || dout_ch !== CW'(g) || dout !== sd || in_ready !== '0) begin
        mismatched++;
        $display("FAIL stall_hold: got valid=%b ch=%0d dout=%h rdy=%b, required 1 %0d %h 000000",
                 dout_valid, dout_ch, dout, in_ready, g, sd);
      end
      step();
    end
    dout_ready = 1'b1;
    rr_run(6'b111111, 1);
    drain();
  endtask

  task automatic test_mode_switch();
    logic [DW-1:0] sd;
    mode = 1'b1; dout_ready = 1'b1;
    rr_run(6'b000100, 1);
    sd = exp_q[exp_q.size()-1][DW-1:0];
    dout_ready = 1'b0; mode = 1'b0; sel = 3'd4; in_valid = 6'b010000;
    rand_data();
    repeat (3) begin
      @(negedge clk);
      compared++;
      if (dout_valid !== 1'b1 || dout_ch !== 3'd2 || dout !== sd || in_ready !== '0) begin
        mismatched++;
        $display("FAIL switch_hold: got valid=%b ch=%0d dout=%h rdy=%b, required 1 2 %h 000000",
                 dout_valid, dout_ch, dout, in_ready, sd);
      end
      step();
    end
    dout_ready = 1'b1;
    @(negedge clk);
    compared++;
    if (in_ready !== 6'b010000) begin
      mismatched++;
      $display("FAIL switch_ready: got %b, required 010000", in_ready);
    end
    exp_q.push_back({3'd4, d[4]});
    m_ptr = ptr_after(4);
    step();
    drain();
  endtask

  initial begin
    test_reset();
    test_static();
    test_bad_sel();
    test_rr_fairness();
    test_stall();
    test_mode_switch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
